// File: rtl/pipe_norm_shift.sv
// Normalisation stage behind the pipelined LZC: delay-matches the operand to the count,
// then shifts the mantissa up to the hidden bit and adjusts the biased exponent.
module pipe_norm_shift #(
  parameter int SIZE     = 64,
  parameter int OUT_SIZE = $clog2(SIZE + 1),
  parameter int EXP_W    = 11,
  parameter int LZC_LAT  = 3,
  parameter int SPLIT    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [SIZE-1:0]     in_mant,
  input  logic [EXP_W-1:0]    in_exp,
  input  logic                in_sign,
  input  logic [OUT_SIZE-1:0] lzc_cnt,
  output logic                out_valid,
  output logic [SIZE-1:0]     out_mant,
  output logic [EXP_W-1:0]    out_exp,
  output logic                out_sign,
  output logic                out_zero,
  output logic                out_denorm
);

  // Side-band fields that ride unchanged alongside the two shift stages.
  typedef struct packed {
    logic             valid;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             zero;
    logic             denorm;
  } side_t;

  logic [LZC_LAT-1:0] dl_valid_q;
  logic [SIZE-1:0]    dl_mant_q [LZC_LAT];
  logic [EXP_W-1:0]   dl_exp_q  [LZC_LAT];
  logic [LZC_LAT-1:0] dl_sign_q;

  // NOTE: the delay-line data is reset along with the valids so a reset leaves no stale
  // operands anywhere in the pipe; use <= throughout so every stage samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid_q <= '0;
      dl_sign_q  <= '0;
      for (int i = 0; i < LZC_LAT; i++) begin
        dl_mant_q[i] <= '0;
        dl_exp_q[i]  <= '0;
      end
    end else begin
      dl_valid_q[0] <= in_valid;
      dl_mant_q[0]  <= in_mant;
      dl_exp_q[0]   <= in_exp;
      dl_sign_q[0]  <= in_sign;
      for (int i = 1; i < LZC_LAT; i++) begin
        dl_valid_q[i] <= dl_valid_q[i-1];
        dl_mant_q[i]  <= dl_mant_q[i-1];
        dl_exp_q[i]   <= dl_exp_q[i-1];
        dl_sign_q[i]  <= dl_sign_q[i-1];
      end
    end
  end

  logic [SIZE-1:0]  d_mant;
  logic [EXP_W-1:0] d_exp;
  logic [EXP_W-1:0] cnt_ext;

  assign d_mant  = dl_mant_q[LZC_LAT-1];
  assign d_exp   = dl_exp_q[LZC_LAT-1];
  assign cnt_ext = EXP_W'(lzc_cnt);

  side_t               s1_side_d, s1_side_q;
  logic [SIZE-1:0]     s1_mant_d, s1_mant_q;
  logic [OUT_SIZE-1:0] s1_shamt_d, s1_shamt_q;

  // Strict greater-than keeps the normal-path exponent at 1 or above; otherwise the shift
  // stops where the exponent would reach 1 and the result is flagged denormal.
  // NOTE: every output of this block is given a default first so no path infers a latch.
  always_comb begin
    s1_side_d.valid  = dl_valid_q[LZC_LAT-1];
    s1_side_d.sign   = dl_sign_q[LZC_LAT-1];
    s1_side_d.exp    = '0;
    s1_side_d.zero   = 1'b0;
    s1_side_d.denorm = 1'b0;
    s1_mant_d        = d_mant;
    s1_shamt_d       = '0;
    if (lzc_cnt == OUT_SIZE'(SIZE)) begin
      s1_side_d.zero = 1'b1;
      s1_mant_d      = '0;
    end else if (d_exp > cnt_ext) begin
      s1_shamt_d    = lzc_cnt;
      s1_side_d.exp = d_exp - cnt_ext;
    end else begin
      s1_side_d.denorm = 1'b1;
      s1_shamt_d       = (d_exp == '0) ? '0 : OUT_SIZE'(d_exp - EXP_W'(1));
    end
  end

  side_t            s2_side_q, s3_side_q;
  logic [SIZE-1:0]  s2_mant_d, s2_mant_q, s3_mant_d, s3_mant_q;
  logic [SPLIT-1:0] s2_fine_q;

  // Coarse shift by whole multiples of 2^SPLIT, then the fine remainder.
  assign s2_mant_d = s1_mant_q << {s1_shamt_q[OUT_SIZE-1:SPLIT], {SPLIT{1'b0}}};
  assign s3_mant_d = s2_mant_q << s2_fine_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_side_q  <= '0;
      s1_mant_q  <= '0;
      s1_shamt_q <= '0;
      s2_side_q  <= '0;
      s2_mant_q  <= '0;
      s2_fine_q  <= '0;
      s3_side_q  <= '0;
      s3_mant_q  <= '0;
    end else begin
      s1_side_q  <= s1_side_d;
      s1_mant_q  <= s1_mant_d;
      s1_shamt_q <= s1_shamt_d;
      s2_side_q  <= s1_side_q;
      s2_mant_q  <= s2_mant_d;
      s2_fine_q  <= s1_shamt_q[SPLIT-1:0];
      s3_side_q  <= s2_side_q;
      s3_mant_q  <= s3_mant_d;
    end
  end

  assign out_valid  = s3_side_q.valid;
  assign out_mant   = s3_mant_q;
  assign out_exp    = s3_side_q.exp;
  assign out_sign   = s3_side_q.sign;
  assign out_zero   = s3_side_q.zero;
  assign out_denorm = s3_side_q.denorm;

endmodule

// File: tb/tb_pipe_norm_shift.sv
// Bench for pipe_norm_shift: behavioural pipelined LZC feeding the DUT, a queue scoreboard,
// a directed vector table, random streaming and an asynchronous mid-flight reset.
`timescale 1ns/1ps
module tb_pipe_norm_shift;

  localparam int SIZE     = 64;
  localparam int OUT_SIZE = $clog2(SIZE + 1);
  localparam int EXP_W    = 11;
  localparam int LZC_LAT  = 3;
  localparam int LAT      = LZC_LAT + 3;

  typedef struct packed {
    logic [SIZE-1:0]  mant;
    logic [EXP_W-1:0] exp;
    logic             sign;
    logic             zero;
    logic             denorm;
  } res_t;

  typedef struct {
    logic [SIZE-1:0]  mant;
    logic [EXP_W-1:0] exp;
    logic             sign;
    res_t             res;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                in_valid;
  logic [SIZE-1:0]     in_mant;
  logic [EXP_W-1:0]    in_exp;
  logic                in_sign;
  logic [OUT_SIZE-1:0] lzc_cnt;
  logic                out_valid;
  logic [SIZE-1:0]     out_mant;
  logic [EXP_W-1:0]    out_exp;
  logic                out_sign;
  logic                out_zero;
  logic                out_denorm;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [OUT_SIZE-1:0] lzc_pipe [LZC_LAT];
  logic [LAT-1:0]      vhist;

  pipe_norm_shift #(.SIZE(SIZE), .EXP_W(EXP_W), .LZC_LAT(LZC_LAT), .SPLIT(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_mant(in_mant), .in_exp(in_exp),
    .in_sign(in_sign), .lzc_cnt(lzc_cnt), .out_valid(out_valid), .out_mant(out_mant),
    .out_exp(out_exp), .out_sign(out_sign), .out_zero(out_zero), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  function automatic int clz(input logic [SIZE-1:0] m);
    int n = SIZE;
    for (int i = 0; i < SIZE; i++) if (m[i]) n = SIZE - 1 - i;
    return n;
  endfunction

  function automatic res_t model(input logic [SIZE-1:0] m, input logic [EXP_W-1:0] e,
                                 input logic s);
    res_t r;
    int   n;
    int   sh;
    n        = clz(m);
    r.sign   = s;
    r.zero   = 1'b0;
    r.denorm = 1'b0;
    if (n == SIZE) begin
      r.mant = '0;
      r.exp  = '0;
      r.zero = 1'b1;
    end else if (int'(e) > n) begin
      r.mant = m << n;
      r.exp  = e - EXP_W'(n);
    end else begin
      sh       = (e == '0) ? 0 : int'(e) - 1;
      r.mant   = m << sh;
      r.exp    = '0;
      r.denorm = 1'b1;
    end
    return r;
  endfunction

  // Pipelined LZC: count for the mantissa presented LZC_LAT cycles earlier.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LZC_LAT; i++) lzc_pipe[i] <= '0;
      vhist <= '0;
    end else begin
      lzc_pipe[0] <= OUT_SIZE'(clz(in_mant));
      for (int i = 1; i < LZC_LAT; i++) lzc_pipe[i] <= lzc_pipe[i-1];
      vhist <= {vhist[LAT-2:0], in_valid};
    end
  end
  assign lzc_cnt = lzc_pipe[LZC_LAT-1];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Output monitor: valid pattern must be the input pattern delayed by LAT cycles.
  always @(negedge clk) begin
    assert (!(rst_n && int'(lzc_cnt) > SIZE))
      else $error("FAIL lzc_range count=%0d exceeds SIZE", lzc_cnt);
    check("out_valid", 128'(out_valid), 128'(vhist[LAT-1]));
    if (out_valid) begin
      check("sb_nonempty", 128'(sb.size() > 0), 128'(1));
      if (sb.size() > 0)
        check("result", 128'({out_mant, out_exp, out_sign, out_zero, out_denorm}),
              128'(sb.pop_front()));
    end
  end

  task automatic drive(input logic v, input logic [SIZE-1:0] m, input logic [EXP_W-1:0] e,
                       input logic s);
    @(negedge clk);
    in_valid = v;
    in_mant  = m;
    in_exp   = e;
    in_sign  = s;
  endtask

  task automatic send_model(input logic [SIZE-1:0] m, input logic [EXP_W-1:0] e,
                            input logic s);
    drive(1'b1, m, e, s);
    sb.push_back(model(m, e, s));
  endtask

  task automatic bubble();
    drive(1'b0, {$urandom, $urandom}, EXP_W'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)));
  endtask

  function automatic logic [SIZE-1:0] rand_mant();
    logic [SIZE-1:0] m;
    int sh;
    m  = {$urandom, $urandom};
    sh = $urandom_range(0, SIZE);
    return (sh == SIZE) ? '0 : (m >> sh);
  endfunction

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{64'h1,                   11'd100,  1'b1, '{64'h8000_0000_0000_0000, 11'd37,   1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{64'h0,                   11'd500,  1'b1, '{64'h0,                    11'd0,    1'b1, 1'b1, 1'b0}};
    vecs[2]  = '{64'h00F0_0000_0000_0000, 11'd5,    1'b0, '{64'h0F00_0000_0000_0000, 11'd0,    1'b0, 1'b0, 1'b1}};
    vecs[3]  = '{64'h2000_0000_0000_0000, 11'd3,    1'b0, '{64'h8000_0000_0000_0000, 11'd1,    1'b0, 1'b0, 1'b0}};
    vecs[4]  = '{64'h2000_0000_0000_0000, 11'd2,    1'b0, '{64'h4000_0000_0000_0000, 11'd0,    1'b0, 1'b0, 1'b1}};
    vecs[5]  = '{64'h2000_0000_0000_0000, 11'd0,    1'b1, '{64'h2000_0000_0000_0000, 11'd0,    1'b1, 1'b0, 1'b1}};
    vecs[6]  = '{64'h8000_0000_0000_0000, 11'd1,    1'b0, '{64'h8000_0000_0000_0000, 11'd1,    1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{64'h8000_0000_0000_0000, 11'd0,    1'b0, '{64'h8000_0000_0000_0000, 11'd0,    1'b0, 1'b0, 1'b1}};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 11'd2047, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFF, 11'd2047, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{64'h1,                   11'd63,   1'b0, '{64'h4000_0000_0000_0000, 11'd0,    1'b0, 1'b0, 1'b1}};
    vecs[10] = '{64'h1,                   11'd64,   1'b1, '{64'h8000_0000_0000_0000, 11'd1,    1'b1, 1'b0, 1'b0}};

    in_valid = 1'b0;
    in_mant  = '0;
    in_exp   = '0;
    in_sign  = 1'b0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", 128'({out_valid, out_mant, out_exp, out_sign, out_zero, out_denorm}), 128'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors, back to back.
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].mant, vecs[i].exp, vecs[i].sign);
      sb.push_back(vecs[i].res);
    end
    repeat (LAT + 2) bubble();
    check("table_drained", 128'(sb.size()), 128'(0));

    // Sustained streaming, then alternating valid/bubble.
    for (int i = 0; i < 20; i++)
      send_model(rand_mant(), EXP_W'($urandom_range(0, 80)), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) send_model(rand_mant(), EXP_W'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)));
      else bubble();
    end
    repeat (LAT + 2) bubble();
    check("stream_drained", 128'(sb.size()), 128'(0));

    // Mid-flight reset: output holds a valid result with more samples behind it.
    for (int i = 0; i < 8; i++)
      send_model(rand_mant() | 64'h1, EXP_W'($urandom_range(1, 2047)), 1'b1);
    @(posedge clk);
    in_valid = 1'b0;
    #2;
    check("pre_reset_valid", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 128'({out_valid, out_mant, out_exp, out_sign, out_zero, out_denorm}), 128'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (10) bubble();
    send_model(64'h0000_0000_0001_0000, 11'd200, 1'b0);
    repeat (LAT + 2) bubble();
    check("final_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
